// File: rtl/hs_arb_pkg.sv
// Shared types and default widths for the hiscore/CPU work-RAM arbiter.
package hs_arb_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAUSE,
    ST_SETTLE,
    ST_GRANT,
    ST_RELEASE
  } hs_arb_state_e;

endpackage

// File: rtl/hs_arb_delay.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module hs_arb_delay
  import hs_arb_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk_49m,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_49m) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/hs_ram_arbiter.sv
// Hands the work-RAM port from the CPU to the hiscore engine around a CPU pause.
// Optional pause watchdog with sticky hs_timeout: define HSARB_WATCHDOG_EN.
module hs_ram_arbiter
  import hs_arb_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int SETTLE  = 4,
  parameter int RELEASE = 2
`ifdef HSARB_WATCHDOG_EN
  ,
  parameter int TIMEOUT = 65535
`endif
) (
  input  logic          clk_49m,
  input  logic          reset,
  input  logic          dl_busy,
  input  logic          hs_req,
  output logic          hs_grant,
  input  logic [AW-1:0] hs_address,
  input  logic [DW-1:0] hs_data_in,
  input  logic          hs_write_enable,
  output logic [DW-1:0] hs_data_out,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          pause_req,
  input  logic          paused,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
`ifdef HSARB_WATCHDOG_EN
  ,
  output logic          hs_timeout
`endif
);

  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] RELEASE_LD = CNT_W'(RELEASE - 1);

  hs_arb_state_e    state;
  logic             start;
  logic             abort;
  logic             go_settle;
  logic             wd_fire;
  logic             grant_end;
  logic             to_release;
  logic             dly_load;
  logic             dly_en;
  logic             dly_done;
  logic [CNT_W-1:0] dly_val;

  assign start      = (state == ST_IDLE) && hs_req && !dl_busy;
  assign abort      = ((state == ST_PAUSE) || (state == ST_SETTLE)) && (!hs_req || dl_busy);
  assign go_settle  = (state == ST_PAUSE) && !abort && paused;
  assign grant_end  = (state == ST_GRANT) && !hs_req;
  assign to_release = abort || wd_fire || grant_end;

  // One counter serves both the settle and the release wait; they never overlap.
  assign dly_load = go_settle || to_release;
  assign dly_val  = to_release ? RELEASE_LD : SETTLE_LD;
  assign dly_en   = (state == ST_SETTLE) || (state == ST_RELEASE);

  hs_arb_delay #(.W(CNT_W)) u_dly (
    .clk_49m (clk_49m),
    .reset   (reset),
    .load    (dly_load),
    .load_val(dly_val),
    .en      (dly_en),
    .done    (dly_done)
  );

`ifdef HSARB_WATCHDOG_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT - 1);

  logic wd_done;

  hs_arb_delay #(.W(CNT_W)) u_wd (
    .clk_49m (clk_49m),
    .reset   (reset),
    .load    (start),
    .load_val(TIMEOUT_LD),
    .en      (state == ST_PAUSE),
    .done    (wd_done)
  );

  assign wd_fire = (state == ST_PAUSE) && !abort && !paused && wd_done;
`else
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk_49m) begin
    if (reset) begin
      state     <= ST_IDLE;
      hs_grant  <= 1'b0;
      pause_req <= 1'b0;
`ifdef HSARB_WATCHDOG_EN
      hs_timeout <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_PAUSE;
            pause_req <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (to_release) begin
            state <= ST_RELEASE;
          end else if (go_settle) begin
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (to_release) begin
            state <= ST_RELEASE;
          end else if (dly_done) begin
            state    <= ST_GRANT;
            hs_grant <= 1'b1;
          end
        end
        ST_GRANT: begin
          // dl_busy and a user unpause are deliberately ignored once granted.
          if (grant_end) begin
            state    <= ST_RELEASE;
            hs_grant <= 1'b0;
          end
        end
        ST_RELEASE: begin
          if (dly_done) begin
            state     <= ST_IDLE;
            pause_req <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          hs_grant  <= 1'b0;
          pause_req <= 1'b0;
        end
      endcase
`ifdef HSARB_WATCHDOG_EN
      if (wd_fire) begin
        hs_timeout <= 1'b1;
      end
`endif
    end
  end

  // CPU keeps address/data on the bus during handover so its reads still work,
  // but its writes are dropped until it owns the port again.
  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_din;
    ram_we   = 1'b0;
    case (state)
      ST_GRANT: begin
        ram_addr = hs_address;
        ram_din  = hs_data_in;
        ram_we   = hs_write_enable;
      end
      ST_IDLE: ram_we = cpu_we;
      default: ram_we = 1'b0;
    endcase
    if (reset) begin
      ram_we = 1'b0;
    end
  end

  // The synchronous RAM already registers its output, so read data is valid
  // one cycle after the address on both return paths.
  assign hs_data_out = ram_dout;
  assign cpu_dout    = ram_dout;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Directed bench for hs_ram_arbiter: vector table for a full session plus corner sequences.
module tb_hs_ram_arbiter;
  import hs_arb_pkg::*;

  logic        clk_49m = 1'b0;
  logic        reset;
  logic        dl_busy;
  logic        hs_req;
  logic        hs_grant;
  logic [11:0] hs_address;
  logic [7:0]  hs_data_in;
  logic        hs_write_enable;
  logic [7:0]  hs_data_out;
  logic [11:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        pause_req;
  logic        paused;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout = 8'h00;
`ifdef HSARB_WATCHDOG_EN
  logic        hs_timeout;
`endif

  logic [2:0]  pdly = 3'b000;
  logic        force_unpause = 1'b0;
  logic [7:0]  mem [0:4095];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_49m = ~clk_49m;

  hs_ram_arbiter #(
    .AW(12), .DW(8), .SETTLE(4), .RELEASE(2)
`ifdef HSARB_WATCHDOG_EN
    , .TIMEOUT(100)
`endif
  ) dut (
    .clk_49m        (clk_49m),
    .reset          (reset),
    .dl_busy        (dl_busy),
    .hs_req         (hs_req),
    .hs_grant       (hs_grant),
    .hs_address     (hs_address),
    .hs_data_in     (hs_data_in),
    .hs_write_enable(hs_write_enable),
    .hs_data_out    (hs_data_out),
    .cpu_addr       (cpu_addr),
    .cpu_we         (cpu_we),
    .cpu_din        (cpu_din),
    .cpu_dout       (cpu_dout),
    .pause_req      (pause_req),
    .paused         (paused),
    .ram_addr       (ram_addr),
    .ram_we         (ram_we),
    .ram_din        (ram_din),
    .ram_dout       (ram_dout)
`ifdef HSARB_WATCHDOG_EN
    , .hs_timeout   (hs_timeout)
`endif
  );

  // Pause system model: paused follows pause_req three cycles later.
  always @(posedge clk_49m) pdly <= {pdly[1:0], pause_req};
  assign paused = pdly[2] & ~force_unpause;

  // Synchronous work RAM, one cycle read latency.
  always @(posedge clk_49m) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic        hs_req;
    logic        dl_busy;
    logic        hs_we;
    logic [11:0] hs_addr;
    logic [7:0]  hs_din;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        e_pause;
    logic        e_grant;
    logic        e_we;
    logic        chk_hs;
    logic [7:0]  e_hs;
    logic        chk_cpu;
    logic [7:0]  e_cpu;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic r, input logic b, input logic hw, input logic [11:0] ha,
                              input logic [7:0] hd, input logic cw, input logic [11:0] ca,
                              input logic [7:0] cd, input logic ep, input logic eg, input logic ew,
                              input logic ch, input logic [7:0] eh, input logic cc, input logic [7:0] ec);
    vec_t v;
    v.hs_req = r;  v.dl_busy = b; v.hs_we = hw; v.hs_addr = ha; v.hs_din = hd;
    v.cpu_we = cw; v.cpu_addr = ca; v.cpu_din = cd;
    v.e_pause = ep; v.e_grant = eg; v.e_we = ew;
    v.chk_hs = ch; v.e_hs = eh; v.chk_cpu = cc; v.e_cpu = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_49m);
  endtask

  task automatic idle_inputs();
    hs_req = 1'b0; dl_busy = 1'b0; hs_write_enable = 1'b0; hs_address = '0; hs_data_in = '0;
    cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
  endtask

  initial begin
    int n;
    logic saw_grant;

    //            req bsy hwe hadr    hdin   cwe cadr    cdin   pr gr we chs ehs    ccp ecp
    tbl[0]  = mk(1, 0, 0, 12'h000, 8'h00, 0, 12'h100, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    tbl[1]  = mk(1, 0, 0, 12'h000, 8'h00, 0, 12'h100, 8'h00, 1, 0, 0, 0, 8'h00, 0, 8'h00);
    tbl[2]  = mk(1, 0, 0, 12'h000, 8'h00, 1, 12'h020, 8'h77, 1, 0, 0, 0, 8'h00, 0, 8'h00);
    tbl[3]  = mk(1, 0, 0, 12'h000, 8'h00, 0, 12'h100, 8'h00, 1, 0, 0, 0, 8'h00, 0, 8'h00);
    tbl[4]  = mk(1, 0, 0, 12'h000, 8'h00, 0, 12'h100, 8'h00, 1, 0, 0, 0, 8'h00, 0, 8'h00);
    tbl[5]  = mk(1, 0, 0, 12'h000, 8'h00, 0, 12'h100, 8'h00, 1, 0, 0, 0, 8'h00, 0, 8'h00);
    tbl[6]  = mk(1, 0, 0, 12'h000, 8'h00, 1, 12'h1F0, 8'h44, 1, 0, 0, 0, 8'h00, 0, 8'h00);
    tbl[7]  = mk(1, 0, 0, 12'h000, 8'h00, 0, 12'h100, 8'h00, 1, 0, 0, 0, 8'h00, 0, 8'h00);
    tbl[8]  = mk(1, 0, 0, 12'h000, 8'h00, 0, 12'h100, 8'h00, 1, 0, 0, 0, 8'h00, 0, 8'h00);
    tbl[9]  = mk(1, 0, 1, 12'h1F0, 8'h5A, 0, 12'h100, 8'h00, 1, 1, 1, 0, 8'h00, 0, 8'h00);
    tbl[10] = mk(1, 0, 0, 12'h1F0, 8'h00, 1, 12'h1F0, 8'h33, 1, 1, 0, 0, 8'h00, 0, 8'h00);
    tbl[11] = mk(1, 0, 0, 12'h1F0, 8'h00, 0, 12'h100, 8'h00, 1, 1, 0, 1, 8'h5A, 0, 8'h00);
    tbl[12] = mk(1, 1, 0, 12'h1F0, 8'h00, 0, 12'h100, 8'h00, 1, 1, 0, 1, 8'h5A, 0, 8'h00);
    tbl[13] = mk(0, 0, 0, 12'h1F0, 8'h00, 0, 12'h100, 8'h00, 1, 1, 0, 0, 8'h00, 0, 8'h00);
    tbl[14] = mk(1, 0, 1, 12'h1F0, 8'hEE, 1, 12'h1F0, 8'hEE, 1, 0, 0, 0, 8'h00, 0, 8'h00);
    tbl[15] = mk(1, 0, 0, 12'h000, 8'h00, 0, 12'h100, 8'h00, 1, 0, 0, 0, 8'h00, 0, 8'h00);
    tbl[16] = mk(0, 0, 0, 12'h000, 8'h00, 1, 12'h010, 8'hA5, 0, 0, 1, 0, 8'h00, 0, 8'h00);
    tbl[17] = mk(0, 0, 0, 12'h000, 8'h00, 0, 12'h010, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    tbl[18] = mk(0, 0, 0, 12'h000, 8'h00, 0, 12'h1F0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 8'hA5);

    idle_inputs();
    reset = 1'b1;
    cpu_we = 1'b1;
    repeat (3) tick();
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_pause_req", pause_req, 1'b0);
    chk("rst_hs_grant", hs_grant, 1'b0);
    chk("rst_state", dut.state, ST_IDLE);
    cpu_we = 1'b0;
    reset = 1'b0;
    repeat (5) tick();

    // Full session, one vector per cycle; expectations describe that same cycle.
    for (int i = 0; i < 19; i++) begin
      hs_req = tbl[i].hs_req; dl_busy = tbl[i].dl_busy;
      hs_write_enable = tbl[i].hs_we; hs_address = tbl[i].hs_addr; hs_data_in = tbl[i].hs_din;
      cpu_we = tbl[i].cpu_we; cpu_addr = tbl[i].cpu_addr; cpu_din = tbl[i].cpu_din;
      #1;
      chk($sformatf("v%0d_pause_req", i), pause_req, tbl[i].e_pause);
      chk($sformatf("v%0d_hs_grant", i), hs_grant, tbl[i].e_grant);
      chk($sformatf("v%0d_ram_we", i), ram_we, tbl[i].e_we);
      if (tbl[i].chk_hs)  chk($sformatf("v%0d_hs_data_out", i), hs_data_out, tbl[i].e_hs);
      if (tbl[i].chk_cpu) chk($sformatf("v%0d_cpu_dout", i), cpu_dout, tbl[i].e_cpu);
      tick();
    end
    idle_inputs();
    repeat (6) tick();

    // Download in progress blocks a new session.
    dl_busy = 1'b1;
    tick();
    hs_req = 1'b1;
    repeat (6) begin
      tick();
      chk("dlbusy_pause_req", pause_req, 1'b0);
    end
    chk("dlbusy_state", dut.state, ST_IDLE);
    idle_inputs();
    repeat (6) tick();

    // Download starting during SETTLE aborts the session.
    hs_req = 1'b1;
    repeat (6) tick();
    chk("abort_in_settle", dut.state, ST_SETTLE);
    dl_busy = 1'b1;
    saw_grant = 1'b0;
    repeat (10) begin
      tick();
      saw_grant |= hs_grant;
    end
    chk("abort_no_grant", saw_grant, 1'b0);
    chk("abort_pause_req", pause_req, 1'b0);
    chk("abort_state", dut.state, ST_IDLE);
    idle_inputs();
    repeat (6) tick();

    // Reset in the middle of a granted session.
    hs_req = 1'b1;
    n = 0;
    while (!hs_grant && n < 40) begin
      tick();
      n++;
    end
    chk("grant_latency", n, 9);
    reset = 1'b1;
    tick();
    chk("midrst_hs_grant", hs_grant, 1'b0);
    chk("midrst_pause_req", pause_req, 1'b0);
    chk("midrst_state", dut.state, ST_IDLE);
    reset = 1'b0;
    idle_inputs();
    repeat (6) tick();

`ifdef HSARB_WATCHDOG_EN
    // Pause never acknowledged: watchdog ends the session and latches hs_timeout.
    force_unpause = 1'b1;
    hs_req = 1'b1;
    n = 0;
    while (!hs_timeout && n < 300) begin
      tick();
      n++;
    end
    chk("wd_latency", n, 101);
    chk("wd_state", dut.state, ST_RELEASE);
    hs_req = 1'b0;
    repeat (6) tick();
    chk("wd_sticky", hs_timeout, 1'b1);
    chk("wd_pause_req", pause_req, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("wd_cleared", hs_timeout, 1'b0);
    force_unpause = 1'b0;
    repeat (4) tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hs_ram_arbiter.md
Name: hs_ram_arbiter

Overview:
- Shares the game's 4 KB work RAM port between the running CPU and the hiscore load/save engine.
- Each hiscore access session follows a fixed sequence: request a CPU pause, wait for the pause acknowledge plus a settle delay, grant the port to hiscore, then release and resume the CPU.
- Sits in the arcade top between the hiscore engine, the pause system and the game core's RAM mux.

Parameters:
- AW, 12, RAM address width.
- DW, 8, RAM data width.
- SETTLE, 4, cycles to wait after `paused` rises before granting (CPU bus quiesce).
- RELEASE, 2, cycles the port is held idle after the grant ends, before `pause_req` drops.
- TIMEOUT, 65535, watchdog limit in cycles for `paused` to arrive (used only with HSARB_WATCHDOG_EN).

Ports:
- clk_49m  in  1  system clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dl_busy  in  1  ROM download in progress; blocks new sessions.
- hs_req  in  1  hiscore session request, level; held high for the whole session.
- hs_grant  out  1  hiscore owns the RAM port.
- hs_address  in  AW  hiscore RAM address.
- hs_data_in  in  DW  hiscore write data.
- hs_write_enable  in  1  hiscore write strobe.
- hs_data_out  out  DW  RAM read data returned to hiscore.
- cpu_addr  in  AW  CPU RAM address.
- cpu_we  in  1  CPU write strobe.
- cpu_din  in  DW  CPU write data.
- cpu_dout  out  DW  RAM read data returned to the CPU.
- pause_req  out  1  to the pause system; requests a CPU halt.
- paused  in  1  from the pause system; CPU is halted.
- ram_addr  out  AW  RAM address.
- ram_we  out  1  RAM write enable.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM read data (synchronous RAM, 1-cycle latency).
- hs_timeout  out  1  sticky watchdog flag (present only with HSARB_WATCHDOG_EN).

Behaviour:
- FSM states: IDLE, PAUSE, SETTLE, GRANT, RELEASE. Reset forces IDLE.
- Reset values: hs_grant=0, pause_req=0, hs_timeout=0, counters=0, ram_we=0.
- IDLE: CPU owns the port. When hs_req=1 and dl_busy=0 -> PAUSE, and pause_req rises the next cycle.
- PAUSE: pause_req=1. When paused=1 -> SETTLE with the counter loaded to SETTLE-1. If hs_req drops first -> RELEASE (abort).
- SETTLE: pause_req=1. Counter decrements each cycle; at 0 -> GRANT.
  - Total latency from the paused rise to the hs_grant rise is SETTLE+1 cycles.
- GRANT: hs_grant=1 and hiscore owns the port.
  - When hs_req drops -> RELEASE, and hs_grant falls the same cycle the state changes.
- RELEASE: hs_grant=0, pause_req=1, ram_we forced 0. After RELEASE cycles -> IDLE and pause_req drops.
- Port mux:
  - ram_addr/ram_din/ram_we come from the hs_* inputs only in GRANT.
  - They come from the cpu_* inputs in IDLE.
  - In PAUSE/SETTLE/RELEASE they are cpu_addr/cpu_din with ram_we=0; CPU writes are suppressed while the handover is pending.
- Read return:
  - hs_data_out = ram_dout, registered; valid 1 cycle after the address, while granted.
  - cpu_dout = ram_dout combinationally passed through, matching direct RAM wiring.
- hs_write_enable outside GRANT is ignored.
- dl_busy rising during PAUSE/SETTLE aborts to RELEASE. dl_busy during GRANT is ignored; the session completes.
- paused dropping during GRANT (user unpause) is ignored; pause_req keeps the CPU halted.
- hs_req re-asserted in RELEASE is not honoured until IDLE has been reached (minimum one IDLE cycle between sessions).
- reset mid-session returns to IDLE immediately, with pause_req and hs_grant low the next cycle.

Optional Feature:
- Macro HSARB_WATCHDOG_EN.
- With it defined:
  - A 16-bit counter runs in PAUSE.
  - Reaching TIMEOUT -> RELEASE and sets hs_timeout.
  - hs_timeout clears only on reset.
- Without it:
  - PAUSE waits indefinitely.
  - The hs_timeout port and the counter are absent.

Decomposition:
- Package hs_arb_pkg holds:
  - the state enum (IDLE, PAUSE, SETTLE, GRANT, RELEASE);
  - default widths AW_DEF=12 and DW_DEF=8.
- One sub-module, hs_arb_delay: a loadable down-counter with a done flag, instantiated for SETTLE and RELEASE and reused for the watchdog.

Test Plan:
- SETTLE=4, RELEASE=2, paused tied to pause_req delayed 3 cycles; pulse hs_req at cycle 10 -> pause_req=1 at 11, paused at 14, hs_grant=1 at 19.
- In GRANT, hs writes 0x5A to 0x1F0 and then reads 0x1F0 -> hs_data_out=0x5A one cycle after the read address. A cpu_we pulse during GRANT leaves the RAM unchanged.
- Drop hs_req in GRANT -> hs_grant=0 the next cycle and pause_req=0 exactly 2 cycles later. The next CPU write of 0xA5 to 0x010 lands.
- Set dl_busy=1 then hs_req=1 -> the FSM stays IDLE and pause_req stays 0. Set dl_busy=1 during SETTLE -> abort, hs_grant never rises.
- Assert reset in GRANT -> hs_grant=0 and pause_req=0 the next cycle, state IDLE.
- With HSARB_WATCHDOG_EN, TIMEOUT=100 and paused held 0 -> after 100 PAUSE cycles, RELEASE; hs_timeout=1 and stays set until reset.
